// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    ADVANCE,
    HALTED
  } fetch_state_t;

  localparam logic [31:0] RESET_VECTOR        = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR_DEFAULT   = 32'h0000_0000;
  localparam int          TIMEOUT_CYC_DEFAULT = 255;
  localparam logic [3:0]  BE_ALL              = 4'b1111;

  // Memory is little-endian; the IR wants the most significant byte first.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Saturating count of bus stall cycles; expired marks the stall cycle that reaches limit.
module fetch_wait_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count_q, count_d;
  logic [W:0]   count_inc;

  assign count_inc = {1'b0, count_q} + {{W{1'b0}}, 1'b1};

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != {W{1'b1}})) begin
      count_d = count_inc[W-1:0];
    end
  end

  // Combinational so the FSM can leave FETCH on the very edge that ends the limit-th stall.
  assign expired = enable && !clear && (count_inc >= {1'b0, limit});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: reads the word at pc over Avalon-MM into the IR, hands it to
// execute, then strobes the PC stage; stops on the halt address or a bus timeout.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR   = HALT_ADDR_DEFAULT,
  parameter int          TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
  parameter bit          BYTE_SWAP   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        exec_done,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch,
  output logic        active,
  output logic        bus_error
);

  localparam logic [7:0] TIMEOUT_LIMIT =
    (TIMEOUT_CYC > 255) ? 8'd255 : 8'(TIMEOUT_CYC);

  fetch_state_t state_q, state_d;
  logic [31:0]  ir_q, ir_d;
  logic         bus_error_q, bus_error_d;

  logic         halt_hit;
  logic         rd_en;
  logic         timer_clear;
  logic         timer_en;
  logic         timer_expired;
  logic [31:0]  rd_word;

  // The halt check is combinational on pc so a halt address never reaches the bus.
  assign halt_hit    = (state_q == FETCH) && (pc == HALT_ADDR);
  assign rd_en       = (state_q == FETCH) && !halt_hit;
  assign timer_clear = (state_q != FETCH);
  assign timer_en    = rd_en && avm_waitrequest;
  assign rd_word     = BYTE_SWAP ? byte_swap32(avm_readdata) : avm_readdata;

  fetch_wait_timer #(
    .W (8)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .limit   (TIMEOUT_LIMIT),
    .expired (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    bus_error_d = bus_error_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (halt_hit) begin
          state_d = HALTED;
        end else if (!avm_waitrequest) begin
          ir_d    = rd_word;
          state_d = ISSUE;
        end else if (timer_expired) begin
          bus_error_d = 1'b1;
          state_d     = HALTED;
        end
      end
      ISSUE: begin
        if (exec_done) begin
          state_d = ADVANCE;
        end
      end
      ADVANCE: begin
        state_d = FETCH;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = HALTED;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ir_q        <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      bus_error_q <= bus_error_d;
    end
  end

  always_comb begin
    avm_read       = rd_en;
    avm_address    = rd_en ? pc : '0;
    avm_byteenable = rd_en ? BE_ALL : 4'b0000;
    instr          = ir_q;
    instr_valid    = (state_q == ISSUE);
    fetch          = (state_q == ADVANCE);
    active         = (state_q != HALTED) && !halt_hit;
    bus_error      = bus_error_q;
  end

endmodule
